// File: rtl/multi_timer.sv
// Multi-channel prescaled timer with byte-lane register bus.
// Each channel counts prescaler ticks up to LIMIT and flags STATUS on match.
module multi_timer #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 32,
   parameter int PRE_W  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        select,
   input  logic [3:0]  wr,
   input  logic        rd,
   input  logic [5:0]  addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        interrupt
);

   localparam logic [5:0] STATUS_ADDR = 6'd32;
   localparam logic [5:0] IRQEN_ADDR  = 6'd33;

   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] per_q, per_d;
   logic [NUM_CH-1:0] status_q, status_d;
   logic [NUM_CH-1:0] irqen_q, irqen_d;
   logic [NUM_CH-1:0] tick, match, w1c;

   logic [PRE_W-1:0] pre_q [NUM_CH];
   logic [PRE_W-1:0] pre_d [NUM_CH];
   logic [PRE_W-1:0] psc_q [NUM_CH];
   logic [PRE_W-1:0] psc_d [NUM_CH];
   logic [WIDTH-1:0] limit_q [NUM_CH];
   logic [WIDTH-1:0] limit_d [NUM_CH];
   logic [WIDTH-1:0] count_q [NUM_CH];
   logic [WIDTH-1:0] count_d [NUM_CH];

   logic        wr_any;
   logic [31:0] lane;
   logic [31:0] rdata;

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] nw,
      input logic [31:0] m
   );
      return (old & ~m) | (nw & m);
   endfunction

   function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
      logic [31:0] w;
      w = '0;
      w[WIDTH-1:0] = v;
      return w;
   endfunction

   function automatic logic [31:0] ctrl_word(
      input logic             en,
      input logic             per,
      input logic [PRE_W-1:0] pre
   );
      logic [31:0] w;
      w = '0;
      w[0] = en;
      w[1] = per;
      w[PRE_W+7:8] = pre;
      return w;
   endfunction

   assign wr_any = select && (wr != 4'b0000);
   assign lane   = {{8{wr[3]}}, {8{wr[2]}}, {8{wr[1]}}, {8{wr[0]}}};

   always_comb begin
      logic [31:0] cw;
      logic [31:0] tw;
      cw       = '0;
      tw       = '0;
      en_d     = en_q;
      per_d    = per_q;
      irqen_d  = irqen_q;
      tick     = '0;
      match    = '0;
      w1c      = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         pre_d[c]   = pre_q[c];
         psc_d[c]   = psc_q[c];
         limit_d[c] = limit_q[c];
         count_d[c] = count_q[c];

         tick[c]  = en_q[c] && (psc_q[c] == pre_q[c]);
         match[c] = tick[c] && (count_q[c] == limit_q[c]);

         if (en_q[c])
            psc_d[c] = tick[c] ? '0 : psc_q[c] + 1'b1;
         // LIMIT below COUNT simply wraps through all ones without a match
         if (tick[c])
            count_d[c] = match[c] ? '0 : count_q[c] + 1'b1;
         if (match[c] && !per_q[c])
            en_d[c] = 1'b0;

         if (wr_any && addr == 6'(4 * c)) begin
            cw = merge(ctrl_word(en_q[c], per_q[c], pre_q[c]),
                       data_in, lane);
            en_d[c]  = cw[0];
            per_d[c] = cw[1];
            pre_d[c] = cw[PRE_W+7:8];
            if (cw[2]) begin
               psc_d[c]   = '0;
               count_d[c] = '0;
            end
         end

         if (wr_any && addr == 6'(4 * c + 1)) begin
            tw = merge(zext(limit_q[c]), data_in, lane);
            limit_d[c] = tw[WIDTH-1:0];
         end

         if (wr_any && addr == 6'(4 * c + 2)) begin
            tw = merge(zext(count_q[c]), data_in, lane);
            count_d[c] = tw[WIDTH-1:0];
         end
      end

      if (wr_any && addr == STATUS_ADDR)
         w1c = data_in[NUM_CH-1:0] & {NUM_CH{wr[0]}};
      // a match in the clear cycle wins
      status_d = (status_q & ~w1c) | match;

      if (wr_any && addr == IRQEN_ADDR && wr[0])
         irqen_d = data_in[NUM_CH-1:0];
   end

   always_comb begin
      rdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (addr == 6'(4 * c))
            rdata = ctrl_word(en_q[c], per_q[c], pre_q[c]);
         if (addr == 6'(4 * c + 1))
            rdata = zext(limit_q[c]);
         if (addr == 6'(4 * c + 2))
            rdata = zext(count_q[c]);
      end
      if (addr == STATUS_ADDR)
         rdata[NUM_CH-1:0] = status_q;
      if (addr == IRQEN_ADDR)
         rdata[NUM_CH-1:0] = irqen_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q     <= '0;
         per_q    <= '0;
         status_q <= '0;
         irqen_q  <= '0;
         data_out <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            pre_q[c]   <= '0;
            psc_q[c]   <= '0;
            limit_q[c] <= '1;
            count_q[c] <= '0;
         end
      end else begin
         en_q     <= en_d;
         per_q    <= per_d;
         status_q <= status_d;
         irqen_q  <= irqen_d;
         if (select && rd)
            data_out <= rdata;
         for (int c = 0; c < NUM_CH; c++) begin
            pre_q[c]   <= pre_d[c];
            psc_q[c]   <= psc_d[c];
            limit_q[c] <= limit_d[c];
            count_q[c] <= count_d[c];
         end
      end
   end

   assign interrupt = |(status_q & irqen_q);

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: register table plus timing sequences.
// Runs a 32-bit and a 16-bit instance side by side on one bus.
module tb_multi_timer;

   logic        clk;
   logic        reset;
   logic        select;
   logic [3:0]  wr;
   logic        rd;
   logic [5:0]  addr;
   logic [31:0] data_in;
   logic [31:0] dout32, dout16;
   logic        irq32, irq16;

   int total = 0;
   int bad = 0;

   multi_timer #(.NUM_CH(4), .WIDTH(32), .PRE_W(8)) u32 (
      .clk(clk), .reset(reset), .select(select), .wr(wr), .rd(rd),
      .addr(addr), .data_in(data_in), .data_out(dout32),
      .interrupt(irq32)
   );

   multi_timer #(.NUM_CH(4), .WIDTH(16), .PRE_W(8)) u16 (
      .clk(clk), .reset(reset), .select(select), .wr(wr), .rd(rd),
      .addr(addr), .data_in(data_in), .data_out(dout16),
      .interrupt(irq16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic [3:0]  be;
      logic [5:0]  a;
      logic [31:0] d;
      logic [31:0] e32;
      logic [31:0] e16;
   } vec_t;

   vec_t tv [$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] be);
      select = 1'b1; wr = be; addr = a; data_in = d;
      @(posedge clk); #1;
      select = 1'b0; wr = 4'h0; data_in = '0;
   endtask

   task automatic bus_rd(input logic [5:0] a, output logic [31:0] q32,
                         output logic [31:0] q16);
      select = 1'b1; rd = 1'b1; addr = a;
      @(posedge clk); #1;
      q32 = dout32; q16 = dout16;
      select = 1'b0; rd = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [31:0] q32, q16;
      logic [31:0] cseq [11];
      cseq = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0};

      reset = 1'b0; select = 1'b0; wr = '0; rd = 1'b0;
      addr = '0; data_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_dout", dout32, 32'h0);
      chk("rst_irq", {31'b0, irq32}, 32'h0);
      reset = 1'b1;

      tv.push_back('{1'b0, 4'h0, 6'd0,  32'h0,        32'h0,        32'h0});
      tv.push_back('{1'b0, 4'h0, 6'd1,  32'h0,        32'hFFFFFFFF, 32'h0000FFFF});
      tv.push_back('{1'b0, 4'h0, 6'd2,  32'h0,        32'h0,        32'h0});
      tv.push_back('{1'b0, 4'h0, 6'd13, 32'h0,        32'hFFFFFFFF, 32'h0000FFFF});
      tv.push_back('{1'b0, 4'h0, 6'd32, 32'h0,        32'h0,        32'h0});
      tv.push_back('{1'b0, 4'h0, 6'd33, 32'h0,        32'h0,        32'h0});
      tv.push_back('{1'b1, 4'hF, 6'd5,  32'hFFFFFFFF, 32'h0,        32'h0});
      tv.push_back('{1'b0, 4'h0, 6'd5,  32'h0,        32'hFFFFFFFF, 32'h0000FFFF});
      tv.push_back('{1'b1, 4'h3, 6'd5,  32'h12345678, 32'h0,        32'h0});
      tv.push_back('{1'b0, 4'h0, 6'd5,  32'h0,        32'hFFFF5678, 32'h00005678});
      tv.push_back('{1'b1, 4'hF, 6'd8,  32'hFFFFFF06, 32'h0,        32'h0});
      tv.push_back('{1'b0, 4'h0, 6'd8,  32'h0,        32'h0000FF02, 32'h0000FF02});
      tv.push_back('{1'b1, 4'hF, 6'd33, 32'hFFFFFFFF, 32'h0,        32'h0});
      tv.push_back('{1'b0, 4'h0, 6'd33, 32'h0,        32'h0000000F, 32'h0000000F});
      tv.push_back('{1'b1, 4'h4, 6'd14, 32'hAABBCCDD, 32'h0,        32'h0});
      tv.push_back('{1'b0, 4'h0, 6'd14, 32'h0,        32'h00BB0000, 32'h0});
      tv.push_back('{1'b1, 4'hF, 6'd3,  32'hFFFFFFFF, 32'h0,        32'h0});
      tv.push_back('{1'b0, 4'h0, 6'd3,  32'h0,        32'h0,        32'h0});
      tv.push_back('{1'b1, 4'hF, 6'd16, 32'hFFFFFFFF, 32'h0,        32'h0});
      tv.push_back('{1'b0, 4'h0, 6'd16, 32'h0,        32'h0,        32'h0});
      tv.push_back('{1'b0, 4'h0, 6'd40, 32'h0,        32'h0,        32'h0});
      tv.push_back('{1'b1, 4'hF, 6'd33, 32'h0,        32'h0,        32'h0});
      tv.push_back('{1'b1, 4'hF, 6'd14, 32'h0,        32'h0,        32'h0});
      tv.push_back('{1'b1, 4'hF, 6'd8,  32'h0,        32'h0,        32'h0});

      for (int i = 0; i < tv.size(); i++) begin
         if (tv[i].w) begin
            bus_wr(tv[i].a, tv[i].d, tv[i].be);
         end else begin
            bus_rd(tv[i].a, q32, q16);
            chk($sformatf("tbl%0d_w32", i), q32, tv[i].e32);
            chk($sformatf("tbl%0d_w16", i), q16, tv[i].e16);
         end
      end
      chk("tbl_irq", {30'b0, irq32, irq16}, 32'h0);

      // periodic ch0, PRE=1, LIMIT=4
      bus_wr(6'd1, 32'd4, 4'hF);
      bus_wr(6'd33, 32'd1, 4'hF);
      bus_wr(6'd0, 32'h103, 4'hF);
      for (int i = 0; i < 11; i++) begin
         bus_rd(6'd2, q32, q16);
         chk($sformatf("per_cnt%0d", i), q32, cseq[i]);
         chk($sformatf("per_irq%0d", i), {31'b0, irq32},
             (i >= 9) ? 32'h1 : 32'h0);
      end
      idle(8);
      bus_wr(6'd32, 32'd1, 4'hF);
      bus_rd(6'd32, q32, q16);
      chk("w1c_vs_match", q32, 32'h1);
      chk("w1c_vs_match_irq", {31'b0, irq32}, 32'h1);
      bus_wr(6'd32, 32'd1, 4'hF);
      chk("w1c_clear_irq", {31'b0, irq32}, 32'h0);
      bus_wr(6'd0, 32'h4, 4'hF);

      // one-shot ch1, LIMIT=2, PRE=0
      bus_wr(6'd5, 32'd2, 4'hF);
      bus_wr(6'd4, 32'h5, 4'hF);
      for (int i = 0; i < 4; i++) begin
         bus_rd(6'd32, q32, q16);
         chk($sformatf("os_stat%0d", i), q32, (i == 3) ? 32'h2 : 32'h0);
      end
      bus_rd(6'd4, q32, q16);
      chk("os_ctrl", q32, 32'h0);
      bus_rd(6'd6, q32, q16);
      chk("os_cnt", q32, 32'h0);
      idle(3);
      bus_rd(6'd6, q32, q16);
      chk("os_cnt_hold", q32, 32'h0);
      chk("os_irq_masked", {31'b0, irq32}, 32'h0);
      bus_wr(6'd32, 32'd2, 4'hF);

      // COUNT write colliding with a tick, lane 0 only
      bus_wr(6'd8, 32'h7, 4'hF);
      bus_wr(6'd10, 32'h12345607, 4'h1);
      bus_rd(6'd10, q32, q16);
      chk("cntwr_w32", q32, 32'h7);
      chk("cntwr_w16", q16, 32'h7);
      bus_rd(6'd10, q32, q16);
      chk("cntwr_next", q32, 32'h8);
      bus_wr(6'd8, 32'h4, 4'hF);

      // LIMIT below COUNT: wrap with no match
      bus_wr(6'd14, 32'hFFFE, 4'hF);
      bus_wr(6'd13, 32'd5, 4'hF);
      bus_wr(6'd12, 32'h3, 4'hF);
      bus_rd(6'd14, q32, q16);
      chk("wrap0_w16", q16, 32'hFFFE);
      bus_rd(6'd14, q32, q16);
      chk("wrap1_w16", q16, 32'hFFFF);
      bus_rd(6'd14, q32, q16);
      chk("wrap2_w16", q16, 32'h0);
      chk("wrap2_w32", q32, 32'h10000);
      bus_rd(6'd32, q32, q16);
      chk("wrap_stat_w16", q16, 32'h0);
      chk("wrap_stat_w32", q32, 32'h0);
      bus_wr(6'd12, 32'h4, 4'hF);

      // ch0 and ch1 match together, only ch1 enabled for irq
      bus_wr(6'd33, 32'd2, 4'hF);
      bus_wr(6'd1, 32'd1, 4'hF);
      bus_wr(6'd5, 32'd0, 4'hF);
      bus_wr(6'd0, 32'h7, 4'hF);
      bus_wr(6'd4, 32'h5, 4'hF);
      idle(1);
      bus_rd(6'd32, q32, q16);
      chk("dual_stat", q32, 32'h3);
      chk("dual_irq", {31'b0, irq32}, 32'h1);
      bus_wr(6'd32, 32'd2, 4'hF);
      chk("dual_irq_clr", {31'b0, irq32}, 32'h0);
      bus_rd(6'd32, q32, q16);
      chk("dual_stat_clr", q32, 32'h1);
      bus_wr(6'd0, 32'h4, 4'hF);
      bus_wr(6'd32, 32'd1, 4'hF);

      // reset pulse mid-count
      bus_wr(6'd33, 32'hF, 4'hF);
      bus_wr(6'd1, 32'd1, 4'hF);
      bus_wr(6'd0, 32'h7, 4'hF);
      idle(3);
      bus_rd(6'd1, q32, q16);
      chk("pre_rst_irq", {31'b0, irq32}, 32'h1);
      idle(1);
      chk("dout_hold", dout32, 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_dout", dout32, 32'h0);
      chk("mid_rst_irq", {30'b0, irq32, irq16}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      bus_rd(6'd0, q32, q16);
      chk("post_ctrl", q32, 32'h0);
      bus_rd(6'd1, q32, q16);
      chk("post_lim_w32", q32, 32'hFFFFFFFF);
      chk("post_lim_w16", q16, 32'h0000FFFF);
      bus_rd(6'd2, q32, q16);
      chk("post_cnt", q32, 32'h0);
      bus_rd(6'd32, q32, q16);
      chk("post_stat", q32, 32'h0);
      bus_rd(6'd33, q32, q16);
      chk("post_irqen", q32, 32'h0);
      idle(5);
      bus_rd(6'd2, q32, q16);
      chk("post_idle_cnt", q32, 32'h0);
      chk("post_irq", {30'b0, irq32, irq16}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 32, count/limit width in bits (8..32).
REQ-003 SHALL have parameter PRE_W, default 8, prescaler width in bits (1..8).
REQ-004 SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port select, input, 1: block selected by bus decode.
REQ-007 SHALL have port wr, input, 4: per-byte write strobes; write occurs when select and any strobe is set.
REQ-008 SHALL have port rd, input, 1: read strobe, qualified by select.
REQ-009 SHALL have port addr, input, 6: word address.
REQ-010 SHALL have port data_in, input, 32: write data.
REQ-011 SHALL have port data_out, output, 32: registered read data.
REQ-012 SHALL have port interrupt, output, 1: level interrupt request.

Function
REQ-013 Map: channel c (c<NUM_CH) word 4c = CTRL, 4c+1 = LIMIT, 4c+2 = COUNT, 4c+3 = reserved (reads 0); word 32 = STATUS; word 33 = IRQEN; other words read 0, writes ignored.
REQ-014 CTRL bits: [0] EN; [1] PERIODIC (1 = periodic, 0 = one-shot); [2] CLR, write-only, self-clearing, reads 0; [PRE_W+7:8] PRE divisor minus one.
REQ-015 Writes honour wr byte lanes; bits at or above WIDTH (LIMIT/COUNT), NUM_CH (STATUS/IRQEN) or PRE_W+8 (CTRL) are discarded; reads zero-extend.
REQ-016 Each channel has a PRE_W-bit prescaler counter; while EN=1 it increments every clk and wraps to 0 after reaching PRE, asserting a one-cycle tick on that wrap.
REQ-017 On tick: if COUNT != LIMIT, COUNT increments by 1; if COUNT == LIMIT, COUNT becomes 0 and STATUS[c] sets.
REQ-018 One-shot: on the match tick, EN clears in the same cycle; PERIODIC keeps EN set.
REQ-019 Period = (LIMIT+1)*(PRE+1) clk cycles from EN rising with COUNT=0 and prescaler=0.
REQ-020 While EN=0, prescaler and COUNT hold their values.
REQ-021 CLR=1 write zeroes COUNT and the prescaler that cycle; other CTRL fields in the same write take effect as written.
REQ-022 Write to COUNT overrides any tick update in the same cycle; the prescaler is unaffected.
REQ-023 Writing LIMIT below the current COUNT causes COUNT to run up to 2^WIDTH-1, then wrap to 0 with no match; STATUS is not set at the wrap.
REQ-024 STATUS is write-1-to-clear per bit; a set event in the same cycle as its clear leaves the bit set.
REQ-025 interrupt = OR over c of (STATUS[c] AND IRQEN[c]), driven from registers, with no combinational path from bus inputs.
REQ-026 data_out updates on the clk after select && rd with the addressed word, and holds otherwise; a read has no side effects.
REQ-027 COUNT read returns the value before any same-cycle tick update.

Reset
REQ-028 On reset low, asynchronously: all CTRL = 0, COUNT = 0, prescalers = 0, LIMIT = all ones (WIDTH bits), STATUS = 0, IRQEN = 0, data_out = 0, interrupt = 0.
REQ-029 Reset asserted mid-count aborts all channels immediately, with no STATUS set or interrupt pulse.
REQ-030 After reset deasserts, no channel counts until software sets EN.

Verification
REQ-031 Ch0 LIMIT=4, PRE=1, PERIODIC=1, IRQEN=1, EN=1 -> STATUS[0] sets every 10 clk; interrupt high from first match until a write of 1 to STATUS bit0; COUNT sequence 0,1,2,3,4,0.
REQ-032 Ch1 one-shot, LIMIT=2, PRE=0 -> STATUS[1] sets after 3 clk; CTRL reads EN=0 afterwards; COUNT stays 0.
REQ-033 STATUS W1C issued in the exact cycle of a ch0 match -> STATUS[0] remains 1.
REQ-034 Write COUNT=0x7 with byte mask 0b0001 coinciding with a tick -> COUNT reads 7 next cycle; write of 0xFFFF_FFFF to LIMIT with WIDTH=16 -> reads 0x0000_FFFF.
REQ-035 Two channels match the same cycle, IRQEN=0b10 -> STATUS=0b11, interrupt driven solely by ch1; clearing bit1 drops interrupt.
REQ-036 Reset pulse mid-count -> all registers at their reset values, including LIMIT=0xFFFF_FFFF for WIDTH=32; no interrupt.
